// File: rtl/pfa_addr_gen_if.sv
// Output beat bus of the PFA index generator: digits, modular address, frame markers.
// Valid/ready handshake; payload is held stable by the master while valid and not ready.
interface pfa_addr_gen_if #(
  parameter int W = 16
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] n1;
  logic [W-1:0] n2;
  logic [W-1:0] n3;
  logic [W-1:0] addr;
  logic         sop;
  logic         eop;

  modport master (
    output out_valid, n1, n2, n3, addr, sop, eop,
    input  out_ready
  );

  modport slave (
    input  out_valid, n1, n2, n3, addr, sop, eop,
    output out_ready
  );
endinterface

// File: rtl/pfa_addr_gen.sv
// Good-Thomas index generator: nested digit counters plus incremental mod-Ntot address, adds only.
// First beat one cycle after start; payload holds while out_ready is low; abort/reset clear it.
module pfa_addr_gen #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic           i_cont,
  input  logic [W-1:0]   i_nf1,
  input  logic [W-1:0]   i_nf2,
  input  logic [W-1:0]   i_nf3,
  input  logic [W-1:0]   i_wt1,
  input  logic [W-1:0]   i_wt2,
  input  logic [W-1:0]   i_wt3,
  input  logic [W-1:0]   i_ntot,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  pfa_addr_gen_if.master m_out
);

  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state;
  logic [W-1:0] r_nf1, r_nf2, r_nf3;
  logic [W-1:0] r_wt1, r_wt2, r_wt3;
  logic [W-1:0] r_ntot;
  logic         r_cont;
  logic [W-1:0] r_n1, r_n2, r_n3;
  logic [W-1:0] r_base1, r_base2, r_addr;
  logic         r_valid, r_sop, r_eop;
  logic         r_busy, r_done, r_err;

  logic [W-1:0] w_nf1m1, w_nf2m1, w_nf3m1;
  logic [W-1:0] w_add1, w_add2, w_add3;
  logic [W-1:0] w_n1n, w_n2n, w_n3n;
  logic [W-1:0] w_b1n, w_b2n, w_addrn;
  logic         w_eopn, w_tx, w_legal, w_start_single, w_cfg_single;

  // Operands are always < m, so a single conditional subtract reduces the sum.
  function automatic logic [W-1:0] addmod(input logic [W-1:0] a, input logic [W-1:0] w,
                                          input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, w};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  assign w_nf1m1 = r_nf1 - ONE;
  assign w_nf2m1 = r_nf2 - ONE;
  assign w_nf3m1 = r_nf3 - ONE;

  assign w_add1 = addmod(r_base1, r_wt1, r_ntot);
  assign w_add2 = addmod(r_base2, r_wt2, r_ntot);
  assign w_add3 = addmod(r_addr,  r_wt3, r_ntot);

  assign w_tx    = r_valid & m_out.out_ready;
  assign w_legal = (i_nf1 != '0) && (i_nf2 != '0) && (i_nf3 != '0) && (i_ntot != '0) &&
                   (i_wt1 < i_ntot) && (i_wt2 < i_ntot) && (i_wt3 < i_ntot);
  assign w_start_single = (i_nf1 == ONE) && (i_nf2 == ONE) && (i_nf3 == ONE);
  assign w_cfg_single   = (r_nf1 == ONE) && (r_nf2 == ONE) && (r_nf3 == ONE);

  // Digit carry chain; a level that rolls over reloads the address from the level above.
  always_comb begin
    w_n1n   = r_n1;
    w_n2n   = r_n2;
    w_n3n   = r_n3;
    w_b1n   = r_base1;
    w_b2n   = r_base2;
    w_addrn = r_addr;
    if (r_n3 != w_nf3m1) begin
      w_n3n   = r_n3 + ONE;
      w_addrn = w_add3;
    end else begin
      w_n3n = '0;
      if (r_n2 != w_nf2m1) begin
        w_n2n   = r_n2 + ONE;
        w_b2n   = w_add2;
        w_addrn = w_add2;
      end else begin
        w_n2n   = '0;
        w_n1n   = r_n1 + ONE;
        w_b1n   = w_add1;
        w_b2n   = w_add1;
        w_addrn = w_add1;
      end
    end
    w_eopn = (w_n1n == w_nf1m1) && (w_n2n == w_nf2m1) && (w_n3n == w_nf3m1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_nf1   <= '0;
      r_nf2   <= '0;
      r_nf3   <= '0;
      r_wt1   <= '0;
      r_wt2   <= '0;
      r_wt3   <= '0;
      r_ntot  <= '0;
      r_cont  <= 1'b0;
      r_n1    <= '0;
      r_n2    <= '0;
      r_n3    <= '0;
      r_base1 <= '0;
      r_base2 <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
        r_n1    <= '0;
        r_n2    <= '0;
        r_n3    <= '0;
        r_base1 <= '0;
        r_base2 <= '0;
        r_addr  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_legal) begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
                r_nf1   <= i_nf1;
                r_nf2   <= i_nf2;
                r_nf3   <= i_nf3;
                r_wt1   <= i_wt1;
                r_wt2   <= i_wt2;
                r_wt3   <= i_wt3;
                r_ntot  <= i_ntot;
                r_cont  <= i_cont;
                r_n1    <= '0;
                r_n2    <= '0;
                r_n3    <= '0;
                r_base1 <= '0;
                r_base2 <= '0;
                r_addr  <= '0;
                r_valid <= 1'b1;
                r_sop   <= 1'b1;
                r_eop   <= w_start_single;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_tx) begin
              if (r_eop) begin
                r_n1    <= '0;
                r_n2    <= '0;
                r_n3    <= '0;
                r_base1 <= '0;
                r_base2 <= '0;
                r_addr  <= '0;
                if (r_cont) begin
                  r_sop <= 1'b1;
                  r_eop <= w_cfg_single;
                end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b0;
                  r_sop   <= 1'b0;
                  r_eop   <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else begin
                r_n1    <= w_n1n;
                r_n2    <= w_n2n;
                r_n3    <= w_n3n;
                r_base1 <= w_b1n;
                r_base2 <= w_b2n;
                r_addr  <= w_addrn;
                r_sop   <= 1'b0;
                r_eop   <= w_eopn;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign m_out.out_valid = r_valid;
  assign m_out.n1        = r_n1;
  assign m_out.n2        = r_n2;
  assign m_out.n3        = r_n3;
  assign m_out.addr      = r_addr;
  assign m_out.sop       = r_sop;
  assign m_out.eop       = r_eop;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;

endmodule

// File: tb/tb_pfa_addr_gen.sv
// Directed bench for pfa_addr_gen: frame table plus hand sequences for cont, abort, err and reset.
module tb_pfa_addr_gen;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0, i_abort = 1'b0, i_cont = 1'b0;
  logic [W-1:0] i_nf1 = '0, i_nf2 = '0, i_nf3 = '0;
  logic [W-1:0] i_wt1 = '0, i_wt2 = '0, i_wt3 = '0, i_ntot = '0;
  logic         o_busy, o_done, o_err;

  pfa_addr_gen_if #(.W(W)) ifc ();

  always #5 clk = ~clk;

  pfa_addr_gen #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_cont (i_cont),
    .i_nf1  (i_nf1),
    .i_nf2  (i_nf2),
    .i_nf3  (i_nf3),
    .i_wt1  (i_wt1),
    .i_wt2  (i_wt2),
    .i_wt3  (i_wt3),
    .i_ntot (i_ntot),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err),
    .m_out  (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int nf1, nf2, nf3;
    int wt1, wt2, wt3;
    int ntot;
    int beats;
    int a0, a1, a2, a3, a4;
    int alast;
    bit perm;
    bit stall;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_cfg(input vec_t v);
    i_nf1 = W'(v.nf1); i_nf2 = W'(v.nf2); i_nf3 = W'(v.nf3);
    i_wt1 = W'(v.wt1); i_wt2 = W'(v.wt2); i_wt3 = W'(v.wt3);
    i_ntot = W'(v.ntot);
  endtask

  // Reference: direct multiply-and-mod of the row-major digits of beat k.
  function automatic int m_n3(input vec_t v, input int k); return k % v.nf3; endfunction
  function automatic int m_n2(input vec_t v, input int k); return (k / v.nf3) % v.nf2; endfunction
  function automatic int m_n1(input vec_t v, input int k); return k / (v.nf2 * v.nf3); endfunction
  function automatic int m_addr(input vec_t v, input int k);
    return (m_n1(v, k) * v.wt1 + m_n2(v, k) * v.wt2 + m_n3(v, k) * v.wt3) % v.ntot;
  endfunction

  function automatic logic [4*W+2:0] snap();
    return {ifc.out_valid, ifc.n1, ifc.n2, ifc.n3, ifc.addr, ifc.sop, ifc.eop};
  endfunction

  task automatic run_frame(input vec_t v, input int tag);
    int          k, cyc, dup;
    int          first[5];
    bit          seen[64];
    bit          prev_stall;
    logic [4*W+2:0] prev;
    first = '{v.a0, v.a1, v.a2, v.a3, v.a4};
    foreach (seen[i]) seen[i] = 1'b0;
    dup = 0; prev_stall = 1'b0; prev = '0;
    @(negedge clk);
    apply_cfg(v);
    i_cont = 1'b0; i_start = 1'b1; ifc.out_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    chk($sformatf("v%0d latency valid", tag), ifc.out_valid, 1);
    chk($sformatf("v%0d latency sop", tag), ifc.sop, 1);
    chk($sformatf("v%0d latency addr", tag), ifc.addr, 0);
    chk($sformatf("v%0d busy", tag), o_busy, 1);
    k = 0; cyc = 0;
    while (k < v.beats && cyc < 3000) begin
      ifc.out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) chk($sformatf("v%0d hold", tag), snap(), prev);
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev = snap();
      if (ifc.out_valid && ifc.out_ready) begin
        chk($sformatf("v%0d addr[%0d]", tag, k), ifc.addr, m_addr(v, k));
        chk($sformatf("v%0d digits[%0d]", tag, k), {ifc.n1, ifc.n2, ifc.n3},
            {W'(m_n1(v, k)), W'(m_n2(v, k)), W'(m_n3(v, k))});
        chk($sformatf("v%0d sop[%0d]", tag, k), ifc.sop, (k == 0));
        chk($sformatf("v%0d eop[%0d]", tag, k), ifc.eop, (k == v.beats - 1));
        if (k < 5) chk($sformatf("v%0d table addr[%0d]", tag, k), ifc.addr, first[k]);
        if (k == v.beats - 1) chk($sformatf("v%0d last addr", tag), ifc.addr, v.alast);
        if (ifc.addr < 64) begin
          if (seen[ifc.addr]) dup++;
          seen[ifc.addr] = 1'b1;
        end
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("v%0d beat count", tag), k, v.beats);
    chk($sformatf("v%0d done pulse", tag), o_done, 1);
    chk($sformatf("v%0d valid after eop", tag), ifc.out_valid, 0);
    chk($sformatf("v%0d busy after eop", tag), o_busy, 0);
    if (v.perm) chk($sformatf("v%0d duplicate addrs", tag), dup, 0);
    @(negedge clk);
    chk($sformatf("v%0d done one cycle", tag), o_done, 0);
  endtask

  initial begin
    int k, cyc;
    vec_t vc;
    ifc.out_ready = 1'b0;
    vt[0] = '{3, 4, 5, 20, 5, 1, 60, 60,   0,  1,  2,  3,  4, 59, 1'b1, 1'b0};
    vt[1] = '{3, 4, 5, 20, 15, 12, 60, 60, 0, 12, 24, 36, 48, 13, 1'b1, 1'b0};
    vt[2] = '{3, 4, 5, 40, 45, 36, 60, 60, 0, 36, 12, 48, 24, 59, 1'b1, 1'b1};
    vt[3] = '{1, 7, 1, 0, 1, 0, 7, 7,      0,  1,  2,  3,  4,  6, 1'b1, 1'b1};
    vt[4] = '{1, 1, 1, 0, 0, 0, 1, 1,      0,  0,  0,  0,  0,  0, 1'b1, 1'b0};
    vt[5] = '{2, 1, 3, 3, 0, 1, 6, 6,      0,  1,  2,  3,  4,  5, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset valid", ifc.out_valid, 0);
    chk("reset bus", {ifc.n1, ifc.n2, ifc.n3, ifc.addr, ifc.sop, ifc.eop}, 0);
    chk("reset flags", {o_busy, o_done, o_err}, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) run_frame(vt[t], t);

    // Continuous mode: two full frames then abort in the third.
    vc = vt[5];
    @(negedge clk);
    apply_cfg(vc); i_cont = 1'b1; i_start = 1'b1; ifc.out_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_cont = 1'b0;
    k = 0; cyc = 0;
    while (k < 15 && cyc < 100) begin
      if (ifc.out_valid) begin
        chk($sformatf("cont addr[%0d]", k), ifc.addr, k % 6);
        chk($sformatf("cont sop[%0d]", k), ifc.sop, (k % 6 == 0));
        chk($sformatf("cont eop[%0d]", k), ifc.eop, (k % 6 == 5));
        k++;
      end
      chk("cont no done", o_done, 0);
      cyc++;
      @(negedge clk);
    end
    chk("cont beat count", k, 15);
    chk("cont addr before abort", ifc.addr, 3);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort valid", ifc.out_valid, 0);
    chk("abort addr", ifc.addr, 0);
    chk("abort busy/done", {o_busy, o_done}, 0);
    @(negedge clk);
    chk("abort no late done", o_done, 0);

    // Illegal parameters: weight equal to modulus, then a zero factor.
    vc = vt[0]; vc.wt3 = 60;
    apply_cfg(vc); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("err wt pulse", o_err, 1);
    chk("err wt busy", {o_busy, ifc.out_valid}, 0);
    @(negedge clk);
    chk("err wt one cycle", o_err, 0);
    vc = vt[0]; vc.nf2 = 0;
    apply_cfg(vc); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("err nf pulse", o_err, 1);
    chk("err nf busy", o_busy, 0);

    // Row-major frame with start/param noise while running, then reset at beat 17.
    @(negedge clk);
    vc = vt[0];
    apply_cfg(vc); i_start = 1'b1; ifc.out_ready = 1'b1;
    @(negedge clk);
    k = 0; cyc = 0;
    while (k < 17 && cyc < 100) begin
      i_start = (k >= 3 && k < 6);
      i_wt3 = 16'd7; i_nf3 = 16'd9;
      if (ifc.out_valid) begin
        chk($sformatf("run-noise addr[%0d]", k), ifc.addr, k);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    i_start = 1'b0;
    chk("rst beat", ifc.addr, 17);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst mid valid", ifc.out_valid, 0);
    chk("rst mid bus", {ifc.n1, ifc.n2, ifc.n3, ifc.addr, ifc.sop, ifc.eop}, 0);
    chk("rst mid flags", {o_busy, o_done, o_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst idle", {o_busy, o_done, o_err, ifc.out_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
